cmp_window_stats: RTL and testbench

- Streaming stage directly downstream of the 8-bit magnitude comparator (eight_bit_comp).
- Accepts a valid/ready stream of unsigned samples and compares each against a threshold, using the same unsigned less/greater/equal semantics as the comparator.
- Over a fixed window of WIN_LEN samples it accumulates the less/greater/equal counts and the running min and max.
- At window end it presents one registered summary record on a valid/ready output.

---
 rtl/cmp_window_stats.sv | 133 +++++++++++++
 tb/tb_cmp_window_stats.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_window_stats.sv
// rtl/cmp_window_stats.sv - windowed lt/gt/eq counts and min/max of a sample stream against a threshold
module cmp_window_stats #(
  parameter int WIDTH   = 8,
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] thresh,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [WIDTH-1:0] out_max,
  output logic [CNT_W-1:0] out_lt_cnt,
  output logic [CNT_W-1:0] out_gt_cnt,
  output logic [CNT_W-1:0] out_eq_cnt
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_thresh_q;
  logic [CNT_W-1:0] r_lt_acc;
  logic [CNT_W-1:0] r_gt_acc;
  logic [CNT_W-1:0] r_eq_acc;
  logic [WIDTH-1:0] r_min_acc;
  logic [WIDTH-1:0] r_max_acc;

  logic             w_take;
  logic             w_first;
  logic             w_last;
  logic [WIDTH-1:0] w_thr;
  logic             w_lt;
  logic             w_gt;
  logic             w_eq;
  logic [CNT_W-1:0] w_lt_nxt;
  logic [CNT_W-1:0] w_gt_nxt;
  logic [CNT_W-1:0] w_eq_nxt;
  logic [WIDTH-1:0] w_min_nxt;
  logic [WIDTH-1:0] w_max_nxt;

  assign w_take  = in_valid && (r_state == ACCUM);
  assign w_first = (r_cnt == '0);
  assign w_last  = (r_cnt == CNT_W'(WIN_LEN - 1));

  // First sample of a window compares against the live threshold; the rest use the captured copy.
  assign w_thr = w_first ? thresh : r_thresh_q;
  assign w_lt  = (in_data < w_thr);
  assign w_gt  = (in_data > w_thr);
  assign w_eq  = (in_data == w_thr);

  assign w_lt_nxt  = r_lt_acc + CNT_W'(w_lt);
  assign w_gt_nxt  = r_gt_acc + CNT_W'(w_gt);
  assign w_eq_nxt  = r_eq_acc + CNT_W'(w_eq);
  assign w_min_nxt = (w_first || (in_data < r_min_acc)) ? in_data : r_min_acc;
  assign w_max_nxt = (w_first || (in_data > r_max_acc)) ? in_data : r_max_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && w_last) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ACCUM;
        end
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt      <= '0;
      r_thresh_q <= '0;
      r_lt_acc   <= '0;
      r_gt_acc   <= '0;
      r_eq_acc   <= '0;
      r_min_acc  <= '0;
      r_max_acc  <= '0;
      out_min    <= '0;
      out_max    <= '0;
      out_lt_cnt <= '0;
      out_gt_cnt <= '0;
      out_eq_cnt <= '0;
    end else if (w_take) begin
      if (w_first) begin
        r_thresh_q <= thresh;
      end
      if (w_last) begin
        out_min    <= w_min_nxt;
        out_max    <= w_max_nxt;
        out_lt_cnt <= w_lt_nxt;
        out_gt_cnt <= w_gt_nxt;
        out_eq_cnt <= w_eq_nxt;
        r_cnt      <= '0;
        r_lt_acc   <= '0;
        r_gt_acc   <= '0;
        r_eq_acc   <= '0;
        r_min_acc  <= '0;
        r_max_acc  <= '0;
      end else begin
        r_cnt     <= r_cnt + 1'b1;
        r_lt_acc  <= w_lt_nxt;
        r_gt_acc  <= w_gt_nxt;
        r_eq_acc  <= w_eq_nxt;
        r_min_acc <= w_min_nxt;
        r_max_acc <= w_max_nxt;
      end
    end
  end

endmodule

// File: tb/tb_cmp_window_stats.sv
// tb/tb_cmp_window_stats.sv - directed checks for cmp_window_stats with WIN_LEN=4 and WIN_LEN=1
module tb_cmp_window_stats;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       a_in_valid = 1'b0;
  logic       a_in_ready;
  logic [7:0] a_in_data  = '0;
  logic [7:0] a_thresh   = '0;
  logic       a_out_valid;
  logic       a_out_ready = 1'b1;
  logic [7:0] a_out_min, a_out_max, a_out_lt, a_out_gt, a_out_eq;

  logic       b_in_valid = 1'b0;
  logic       b_in_ready;
  logic [7:0] b_in_data  = '0;
  logic [7:0] b_thresh   = '0;
  logic       b_out_valid;
  logic       b_out_ready = 1'b1;
  logic [7:0] b_out_min, b_out_max, b_out_lt, b_out_gt, b_out_eq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmp_window_stats #(.WIDTH(8), .WIN_LEN(4), .CNT_W(8)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .thresh(a_thresh),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_min(a_out_min), .out_max(a_out_max),
    .out_lt_cnt(a_out_lt), .out_gt_cnt(a_out_gt), .out_eq_cnt(a_out_eq)
  );

  cmp_window_stats #(.WIDTH(8), .WIN_LEN(1), .CNT_W(8)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .thresh(b_thresh),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_min(b_out_min), .out_max(b_out_max),
    .out_lt_cnt(b_out_lt), .out_gt_cnt(b_out_gt), .out_eq_cnt(b_out_eq)
  );

  // Called at a negedge; presents one sample and returns at the negedge after it transfers.
  task automatic send_a(input logic [7:0] d, input logic [7:0] t);
    int n = 0;
    while (!a_in_ready && n < 20) begin
      a_in_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL send_a_timeout: in_ready stayed 0, required 1");
    end
    a_in_valid = 1'b1;
    a_in_data  = d;
    a_thresh   = t;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic [7:0] t);
    int n = 0;
    while (!b_in_ready && n < 20) begin
      b_in_valid = 1'b0;
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL send_b_timeout: in_ready stayed 0, required 1");
    end
    b_in_valid = 1'b1;
    b_in_data  = d;
    b_thresh   = t;
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  task automatic idle_a(input int n);
    a_in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({a_in_ready, a_out_valid, a_out_min, a_out_max, a_out_lt, a_out_gt, a_out_eq} !== {1'b1, 1'b0, 40'h0}) begin
      bad++;
      $display("FAIL reset_a: got rdy=%b vld=%b min=%0d max=%0d lt=%0d gt=%0d eq=%0d, required rdy=1 vld=0 rest 0",
               a_in_ready, a_out_valid, a_out_min, a_out_max, a_out_lt, a_out_gt, a_out_eq);
    end
    total++;
    if ({b_in_ready, b_out_valid, b_out_min, b_out_max, b_out_lt, b_out_gt, b_out_eq} !== {1'b1, 1'b0, 40'h0}) begin
      bad++;
      $display("FAIL reset_b: got rdy=%b vld=%b min=%0d max=%0d, required rdy=1 vld=0 rest 0",
               b_in_ready, b_out_valid, b_out_min, b_out_max);
    end
  endtask

  task automatic test_basic;
    a_out_ready = 1'b1;
    send_a(8'd125, 8'd100);
    send_a(8'd140, 8'd100);
    send_a(8'd100, 8'd100);
    send_a(8'd20,  8'd100);
    total++;
    if ({a_out_valid, a_in_ready} !== 2'b10) begin
      bad++;
      $display("FAIL basic_hold: got vld=%b rdy=%b, required vld=1 rdy=0", a_out_valid, a_in_ready);
    end
    total++;
    if ({a_out_lt, a_out_gt, a_out_eq, a_out_min, a_out_max} !== {8'd1, 8'd2, 8'd1, 8'd20, 8'd140}) begin
      bad++;
      $display("FAIL basic_record: got lt=%0d gt=%0d eq=%0d min=%0d max=%0d, required 1 2 1 20 140",
               a_out_lt, a_out_gt, a_out_eq, a_out_min, a_out_max);
    end
    @(negedge clk);
    total++;
    if ({a_out_valid, a_in_ready} !== 2'b01) begin
      bad++;
      $display("FAIL basic_release: got vld=%b rdy=%b, required vld=0 rdy=1", a_out_valid, a_in_ready);
    end
  endtask

  task automatic test_thresh_capture;
    send_a(8'd200, 8'd200);
    send_a(8'd210, 8'd0);
    send_a(8'd200, 8'd0);
    send_a(8'd130, 8'd0);
    total++;
    if ({a_out_valid, a_out_lt, a_out_gt, a_out_eq, a_out_min, a_out_max} !== {1'b1, 8'd1, 8'd1, 8'd2, 8'd130, 8'd210}) begin
      bad++;
      $display("FAIL thresh_capture: got vld=%b lt=%0d gt=%0d eq=%0d min=%0d max=%0d, required 1 1 1 2 130 210",
               a_out_valid, a_out_lt, a_out_gt, a_out_eq, a_out_min, a_out_max);
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int stable_bad = 0;
    a_out_ready = 1'b0;
    send_a(8'd125, 8'd100);
    send_a(8'd140, 8'd100);
    send_a(8'd100, 8'd100);
    send_a(8'd20,  8'd100);
    for (int i = 0; i < 5; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'h55;
      a_thresh   = 8'h55;
      if ({a_out_valid, a_in_ready, a_out_lt, a_out_gt, a_out_eq, a_out_min, a_out_max} !==
          {1'b1, 1'b0, 8'd1, 8'd2, 8'd1, 8'd20, 8'd140})
        stable_bad++;
      @(negedge clk);
    end
    total++;
    if (stable_bad != 0) begin
      bad++;
      $display("FAIL bp_stable: %0d unstable cycles, required 0", stable_bad);
    end
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(negedge clk);
    total++;
    if ({a_out_valid, a_in_ready, a_out_min, a_out_max} !== {1'b0, 1'b1, 8'd20, 8'd140}) begin
      bad++;
      $display("FAIL bp_accept: got vld=%b rdy=%b min=%0d max=%0d, required 0 1 20 140",
               a_out_valid, a_in_ready, a_out_min, a_out_max);
    end
    send_a(8'd5, 8'd5);
    send_a(8'd5, 8'd5);
    send_a(8'd5, 8'd5);
    send_a(8'd5, 8'd5);
    total++;
    if ({a_out_valid, a_out_lt, a_out_gt, a_out_eq, a_out_min, a_out_max} !== {1'b1, 8'd0, 8'd0, 8'd4, 8'd5, 8'd5}) begin
      bad++;
      $display("FAIL bp_not_consumed: got vld=%b lt=%0d gt=%0d eq=%0d min=%0d max=%0d, required 1 0 0 4 5 5",
               a_out_valid, a_out_lt, a_out_gt, a_out_eq, a_out_min, a_out_max);
    end
    @(negedge clk);
  endtask

  task automatic test_gapped;
    send_a(8'hFF, 8'd10);
    idle_a(3);
    send_a(8'h00, 8'd0);
    send_a(8'h0A, 8'd0);
    idle_a(1);
    total++;
    if (a_out_valid !== 1'b0) begin
      bad++;
      $display("FAIL gapped_early: got vld=%b, required 0", a_out_valid);
    end
    send_a(8'h14, 8'd0);
    total++;
    if ({a_out_valid, a_out_lt, a_out_gt, a_out_eq, a_out_min, a_out_max} !== {1'b1, 8'd1, 8'd2, 8'd1, 8'h00, 8'hFF}) begin
      bad++;
      $display("FAIL gapped_record: got vld=%b lt=%0d gt=%0d eq=%0d min=%0h max=%0h, required 1 1 2 1 00 ff",
               a_out_valid, a_out_lt, a_out_gt, a_out_eq, a_out_min, a_out_max);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_window;
    send_a(8'd7, 8'd3);
    send_a(8'd8, 8'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({a_in_ready, a_out_valid, a_out_min, a_out_max, a_out_lt, a_out_gt, a_out_eq} !== {1'b1, 1'b0, 40'h0}) begin
      bad++;
      $display("FAIL midreset_outputs: got rdy=%b vld=%b min=%0d max=%0d lt=%0d gt=%0d eq=%0d, required rdy=1 rest 0",
               a_in_ready, a_out_valid, a_out_min, a_out_max, a_out_lt, a_out_gt, a_out_eq);
    end
    send_a(8'd2, 8'd2);
    send_a(8'd1, 8'd2);
    send_a(8'd2, 8'd2);
    send_a(8'd1, 8'd2);
    total++;
    if ({a_out_valid, a_out_lt, a_out_gt, a_out_eq, a_out_min, a_out_max} !== {1'b1, 8'd2, 8'd0, 8'd2, 8'd1, 8'd2}) begin
      bad++;
      $display("FAIL midreset_record: got vld=%b lt=%0d gt=%0d eq=%0d min=%0d max=%0d, required 1 2 0 2 1 2",
               a_out_valid, a_out_lt, a_out_gt, a_out_eq, a_out_min, a_out_max);
    end
    @(negedge clk);
  endtask

  task automatic test_win_len_one;
    b_out_ready = 1'b1;
    send_b(8'd21, 8'd100);
    total++;
    if ({b_out_valid, b_out_lt, b_out_gt, b_out_eq, b_out_min, b_out_max} !== {1'b1, 8'd1, 8'd0, 8'd0, 8'd21, 8'd21}) begin
      bad++;
      $display("FAIL win1_first: got vld=%b lt=%0d gt=%0d eq=%0d min=%0d max=%0d, required 1 1 0 0 21 21",
               b_out_valid, b_out_lt, b_out_gt, b_out_eq, b_out_min, b_out_max);
    end
    @(negedge clk);
    send_b(8'd200, 8'd100);
    total++;
    if ({b_out_valid, b_out_lt, b_out_gt, b_out_eq, b_out_min, b_out_max} !== {1'b1, 8'd0, 8'd1, 8'd0, 8'd200, 8'd200}) begin
      bad++;
      $display("FAIL win1_second: got vld=%b lt=%0d gt=%0d eq=%0d min=%0d max=%0d, required 1 0 1 0 200 200",
               b_out_valid, b_out_lt, b_out_gt, b_out_eq, b_out_min, b_out_max);
    end
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_basic;
    test_thresh_capture;
    test_backpressure;
    test_gapped;
    test_reset_mid_window;
    test_win_len_one;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
